// File: rtl/spi_master_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_sequencer
// Brief    : Round-robin arbiter that shares one SPI slave among NUM_REQ
//            requesters, sequencing an address frame, a data frame and an
//            optional MISO read-return phase with timeout.
// Revision : 1.0  initial release
// ============================================================================
module spi_master_sequencer #(
    parameter int NUM_REQ    = 2,
    parameter int GAP_CYCLES = 4,
    parameter int RD_TIMEOUT = 32,
    localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [8*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   busy,
    output logic                   done,
    output logic [IDW-1:0]         done_id,
    output logic [7:0]             rdata,
    output logic                   rd_err,
    output logic                   ss_n,
    output logic                   MOSI,
    input  logic                   MISO,
    input  logic                   miso_valid
);

    localparam int CMAX0 = (RD_TIMEOUT > GAP_CYCLES) ? RD_TIMEOUT : GAP_CYCLES;
    localparam int CMAX  = (CMAX0 > 9) ? CMAX0 : 9;
    localparam int CW    = $clog2(CMAX + 1);

    localparam logic [CW-1:0]  c_bit_last = CW'(9);
    localparam logic [CW-1:0]  c_gap_last = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0]  c_to_last  = CW'(RD_TIMEOUT - 1);
    localparam logic [CW-1:0]  c_cnt_one  = CW'(1);
    localparam logic [IDW:0]   c_nreq     = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0] c_last_id  = IDW'(NUM_REQ - 1);
    localparam logic [IDW-1:0] c_id_one   = IDW'(1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_SETUP_A = 4'd1,
        S_SHIFT_A = 4'd2,
        S_GAP     = 4'd3,
        S_SETUP_B = 4'd4,
        S_SHIFT_B = 4'd5,
        S_RD_WAIT = 4'd6,
        S_DONE    = 4'd7,
        S_POST    = 4'd8
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [9:0]           frame_q, frame_d;
    logic                 wr_q, wr_d;
    logic [7:0]           wdata_q, wdata_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [2:0]           samp_q, samp_d;
    logic [6:0]           sr_q, sr_d;
    logic [7:0]           rdata_q, rdata_d;
    logic                 rd_err_q, rd_err_d;
    logic [IDW-1:0]       done_id_q, done_id_d;

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic                 win_found;
    logic [IDW:0]         win_sum;
    logic [IDW-1:0]       win_id;
    logic [IDW-1:0]       ptr_next;

    // Rotate requests so bit 0 is the pointer position; lowest set bit wins.
    always_comb begin
        req_dbl   = {req, req};
        req_rot   = NUM_REQ'(req_dbl >> ptr_q);
        win_found = 1'b0;
        win_sum   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_found = 1'b1;
                win_sum   = {1'b0, ptr_q} + (IDW+1)'(k);
            end
        end
        win_id   = IDW'((win_sum >= c_nreq) ? (win_sum - c_nreq) : win_sum);
        ptr_next = (win_id == c_last_id) ? '0 : (win_id + c_id_one);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            frame_q   <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            id_q      <= '0;
            ptr_q     <= '0;
            gnt_q     <= '0;
            samp_q    <= '0;
            sr_q      <= '0;
            rdata_q   <= '0;
            rd_err_q  <= 1'b0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            samp_q    <= samp_d;
            sr_q      <= sr_d;
            rdata_q   <= rdata_d;
            rd_err_q  <= rd_err_d;
            done_id_q <= done_id_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        frame_d   = frame_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        gnt_d     = '0;
        samp_d    = samp_q;
        sr_d      = sr_q;
        rdata_d   = rdata_q;
        rd_err_d  = rd_err_q;
        done_id_d = done_id_q;
        ss_n      = 1'b1;
        MOSI      = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (win_found) begin
                    state_d = S_SETUP_A;
                    gnt_d   = NUM_REQ'(1) << win_id;
                    wr_d    = req_write[win_id];
                    wdata_d = req_wdata[{win_id, 3'b000} +: 8];
                    frame_d = {~req_write[win_id], 1'b0, req_addr[{win_id, 3'b000} +: 8]};
                    id_d    = win_id;
                    ptr_d   = ptr_next;
                end
            end
            S_SETUP_A: begin
                ss_n    = 1'b0;
                state_d = S_SHIFT_A;
                cnt_d   = c_bit_last;
            end
            S_SHIFT_A: begin
                ss_n    = 1'b0;
                MOSI    = frame_q[9];
                frame_d = {frame_q[8:0], 1'b0};
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = c_gap_last;
                end else begin
                    cnt_d = cnt_q - c_cnt_one;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_SETUP_B;
                    frame_d = {~wr_q, 1'b1, (wr_q ? wdata_q : 8'h00)};
                end else begin
                    cnt_d = cnt_q - c_cnt_one;
                end
            end
            S_SETUP_B: begin
                ss_n    = 1'b0;
                state_d = S_SHIFT_B;
                cnt_d   = c_bit_last;
            end
            S_SHIFT_B: begin
                ss_n    = 1'b0;
                MOSI    = frame_q[9];
                frame_d = {frame_q[8:0], 1'b0};
                if (cnt_q == '0) begin
                    if (wr_q) begin
                        state_d   = S_DONE;
                        rdata_d   = 8'h00;
                        rd_err_d  = 1'b0;
                        done_id_d = id_q;
                    end else begin
                        state_d = S_RD_WAIT;
                        cnt_d   = '0;
                        samp_d  = '0;
                        sr_d    = '0;
                    end
                end else begin
                    cnt_d = cnt_q - c_cnt_one;
                end
            end
            S_RD_WAIT: begin
                ss_n = 1'b0;
                if (miso_valid) begin
                    sr_d   = {sr_q[5:0], MISO};
                    samp_d = samp_q + 3'd1;
                end
                // A final sample arriving on the timeout cycle still counts as success.
                if (miso_valid && (samp_q == 3'd7)) begin
                    state_d   = S_DONE;
                    rdata_d   = {sr_q, MISO};
                    rd_err_d  = 1'b0;
                    done_id_d = id_q;
                end else if (cnt_q == c_to_last) begin
                    state_d   = S_DONE;
                    rdata_d   = 8'h00;
                    rd_err_d  = 1'b1;
                    done_id_d = id_q;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_POST;
                cnt_d   = c_gap_last;
            end
            S_POST: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - c_cnt_one;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign gnt     = gnt_q;
    assign done_id = done_id_q;
    assign rdata   = rdata_q;
    assign rd_err  = rd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_sequencer
// Brief    : Scoreboard bench for spi_master_sequencer: frames, timing,
//            read returns, timeout, round-robin order and mid-frame reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_master_sequencer;

    localparam int NUM_REQ   = 2;
    localparam int GAP       = 4;
    localparam int RDTO      = 32;
    localparam int IDW       = 1;
    // Offsets relative to the gnt cycle (gnt = 0).
    localparam int FA_START  = 1;
    localparam int GAP_START = FA_START + 10;
    localparam int FB_START  = GAP_START + GAP + 1;
    localparam int RDW_START = FB_START + 10;
    localparam int TXN_PITCH = RDW_START + 1 + GAP + 1;
    localparam int HIST      = 128;
    localparam int LIMIT     = 200;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_REQ-1:0]     req, req_write, gnt;
    logic [8*NUM_REQ-1:0]   req_addr, req_wdata;
    logic                   busy, done, rd_err, ss_n, MOSI, MISO, miso_valid;
    logic [IDW-1:0]         done_id;
    logic [7:0]             rdata;

    always #5 clk = ~clk;

    spi_master_sequencer #(
        .NUM_REQ    (NUM_REQ),
        .GAP_CYCLES (GAP),
        .RD_TIMEOUT (RDTO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .gnt        (gnt),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id),
        .rdata      (rdata),
        .rd_err     (rd_err),
        .ss_n       (ss_n),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .miso_valid (miso_valid)
    );

    typedef struct {
        int         id;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    int         cap_gnt_t, cap_done_t, cap_gid;
    logic       cap_ss   [HIST];
    logic       cap_mosi [HIST];
    logic [IDW-1:0] cap_did;
    logic [7:0] cap_rdata;
    logic       cap_err, cap_ss_done, cap_ss_pre;

    int         h_ng, h_nd;
    int         h_gid [8];
    int         h_gt  [8];
    int         h_did [8];
    logic [7:0] h_rd  [8];
    logic       h_err [8];

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = (r < 0) ? i : -2;
        return r;
    endfunction

    function automatic exp_t sb_pop();
        exp_t x;
        x.id = -1; x.rdata = 8'hxx; x.err = 1'bx;
        if (sb.size() > 0) x = sb.pop_front();
        return x;
    endfunction

    // Single transaction from one requester, with a simple slave model.
    // vmode: 0 none, 1 contiguous valid (plus junk valid before RD_WAIT), 2 every other cycle.
    task automatic drive_txn(input int id, input logic wr, input logic [7:0] addr,
                             input logic [7:0] wdata, input int vmode, input logic [7:0] mbyte);
        int gt, o;
        logic prev_ss;
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        gt = -1; cap_gnt_t = -1; cap_done_t = -1; cap_gid = -1; prev_ss = 1'b1;
        for (int i = 0; i < HIST; i++) begin cap_ss[i] = 1'b1; cap_mosi[i] = 1'b0; end
        req_write[id] = wr;
        req_addr[id*8 +: 8] = addr;
        req_wdata[id*8 +: 8] = wdata;
        req[id] = 1'b1;
        for (int t = 1; t <= LIMIT; t++) begin
            @(negedge clk);
            miso_valid = 1'b0;
            MISO = 1'b0;
            if (gt < 0 && gnt != '0) begin
                gt = t; cap_gnt_t = t; cap_gid = onehot_idx(gnt);
                req[id] = 1'b0;
            end
            if (gt >= 0 && (t - gt) < HIST) begin
                cap_ss[t-gt] = ss_n;
                cap_mosi[t-gt] = MOSI;
            end
            if (done) begin
                cap_done_t = t; cap_did = done_id; cap_rdata = rdata; cap_err = rd_err;
                cap_ss_done = ss_n; cap_ss_pre = prev_ss;
                break;
            end
            prev_ss = ss_n;
            if (gt >= 0) begin
                o = t - gt - RDW_START;
                if (vmode == 1) begin
                    if (o < 0) begin miso_valid = 1'b1; MISO = 1'b1; end
                    else if (o < 8) begin miso_valid = 1'b1; MISO = mbyte[7-o]; end
                end else if (vmode == 2) begin
                    if (o >= 0 && o < 16 && (o % 2) == 0) begin miso_valid = 1'b1; MISO = mbyte[7-o/2]; end
                end
            end
        end
        req[id] = 1'b0;
    endtask

    task automatic run_held(input logic [NUM_REQ-1:0] mask, input int n);
        int ng, nd;
        ng = 0; nd = 0;
        req = mask;
        for (int t = 1; t <= n * 60; t++) begin
            @(negedge clk);
            if (gnt != '0 && ng < 8) begin h_gid[ng] = onehot_idx(gnt); h_gt[ng] = t; ng++; end
            if (done && nd < 8) begin
                h_did[nd] = int'(done_id); h_rd[nd] = rdata; h_err[nd] = rd_err; nd++;
                if (nd == n) break;
            end
        end
        req = '0;
        h_ng = ng; h_nd = nd;
    endtask

    task automatic check_frames(input string nm, input logic [9:0] exp_a, input logic [9:0] exp_b);
        logic [9:0] fa, fb;
        int hi;
        fa = '0; fb = '0; hi = 0;
        for (int i = 0; i < 10; i++) begin
            fa = {fa[8:0], cap_mosi[FA_START+i]};
            fb = {fb[8:0], cap_mosi[FB_START+i]};
        end
        for (int i = GAP_START; i < GAP_START + GAP; i++) if (cap_ss[i]) hi++;
        total++;
        if (fa !== exp_a) begin bad++; $display("FAIL %s frameA got=%b want=%b", nm, fa, exp_a); end
        total++;
        if (fb !== exp_b) begin bad++; $display("FAIL %s frameB got=%b want=%b", nm, fb, exp_b); end
        total++;
        if (hi != GAP || cap_ss[GAP_START-1] !== 1'b0 || cap_ss[FB_START-1] !== 1'b0) begin
            bad++; $display("FAIL %s gap ss_n-high=%0d want=%0d", nm, hi, GAP);
        end
    endtask

    task automatic check_done(input string nm, input int lat);
        exp_t e;
        e = sb_pop();
        total++;
        if (cap_done_t < 0) begin
            bad++; $display("FAIL %s done timeout got=none want=latency %0d", nm, lat);
        end else begin
            if (cap_done_t - cap_gnt_t != lat) begin
                bad++; $display("FAIL %s done_latency got=%0d want=%0d", nm, cap_done_t - cap_gnt_t, lat);
            end
            total++;
            if (int'(cap_did) != e.id || cap_rdata !== e.rdata || cap_err !== e.err) begin
                bad++; $display("FAIL %s done fields got id=%0d rdata=%h err=%b want id=%0d rdata=%h err=%b",
                                nm, cap_did, cap_rdata, cap_err, e.id, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_reset();
        req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        MISO = 1'b0; miso_valid = 1'b0; rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (ss_n !== 1'b1 || MOSI !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || gnt !== '0) begin
            bad++; $display("FAIL reset ctl got ss_n=%b mosi=%b busy=%b done=%b gnt=%b want 1 0 0 0 00",
                            ss_n, MOSI, busy, done, gnt);
        end
        total++;
        if (rdata !== 8'h00 || rd_err !== 1'b0 || done_id !== '0) begin
            bad++; $display("FAIL reset data got rdata=%h rd_err=%b done_id=%0d want 00 0 0", rdata, rd_err, done_id);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        sb.push_back('{0, 8'h00, 1'b0});
        drive_txn(0, 1'b1, 8'hA5, 8'h3C, 0, 8'h00);
        total++;
        if (cap_gnt_t != 1 || cap_gid != 0) begin
            bad++; $display("FAIL write gnt got t=%0d id=%0d want t=1 id=0", cap_gnt_t, cap_gid);
        end
        check_frames("write", {2'b00, 8'hA5}, {2'b01, 8'h3C});
        // gnt and done cycles inclusive span 27 cycles.
        check_done("write", RDW_START);
    endtask

    task automatic test_read();
        sb.push_back('{1, 8'hC9, 1'b0});
        drive_txn(1, 1'b0, 8'h12, 8'h00, 1, 8'hC9);
        total++;
        if (cap_gid != 1) begin bad++; $display("FAIL read gnt id got=%0d want=1", cap_gid); end
        check_frames("read", {2'b10, 8'h12}, {2'b11, 8'h00});
        check_done("read", RDW_START + 8);
        total++;
        if (cap_ss_done !== 1'b1 || cap_ss_pre !== 1'b0) begin
            bad++; $display("FAIL read ss_n edge got pre=%b done=%b want 0 1", cap_ss_pre, cap_ss_done);
        end
    endtask

    task automatic test_read_timeout();
        sb.push_back('{1, 8'h00, 1'b1});
        drive_txn(1, 1'b0, 8'h12, 8'h00, 0, 8'h00);
        check_done("timeout", RDW_START + RDTO);
    endtask

    task automatic test_gapped_valid();
        sb.push_back('{0, 8'h5A, 1'b0});
        drive_txn(0, 1'b0, 8'h77, 8'h00, 2, 8'h5A);
        check_frames("gapped", {2'b10, 8'h77}, {2'b11, 8'h00});
        check_done("gapped", RDW_START + 15);
    endtask

    task automatic test_round_robin();
        exp_t e;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        req_write = 2'b11; req_addr = {8'h22, 8'h11}; req_wdata = {8'hBB, 8'hAA};
        for (int i = 0; i < 4; i++) sb.push_back('{i % 2, 8'h00, 1'b0});
        run_held(2'b11, 4);
        total++;
        if (h_nd != 4 || h_ng != 4) begin bad++; $display("FAIL rr count got gnts=%0d dones=%0d want 4 4", h_ng, h_nd); end
        for (int i = 0; i < h_ng && i < 4; i++) begin
            total++;
            if (h_gid[i] != i % 2) begin bad++; $display("FAIL rr order[%0d] got=%0d want=%0d", i, h_gid[i], i % 2); end
            if (i > 0) begin
                total++;
                if (h_gt[i] - h_gt[i-1] != TXN_PITCH) begin
                    bad++; $display("FAIL rr pitch[%0d] got=%0d want=%0d", i, h_gt[i] - h_gt[i-1], TXN_PITCH);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            e = sb_pop();
            if (i < h_nd) begin
                total++;
                if (h_did[i] != e.id || h_rd[i] !== e.rdata || h_err[i] !== e.err) begin
                    bad++; $display("FAIL rr done[%0d] got id=%0d rdata=%h err=%b want id=%0d rdata=%h err=%b",
                                    i, h_did[i], h_rd[i], h_err[i], e.id, e.rdata, e.err);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int gt, nd;
        gt = -1; nd = 0;
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        req_write[0] = 1'b1; req_addr[7:0] = 8'hA5; req_wdata[7:0] = 8'h3C;
        req[0] = 1'b1;
        for (int t = 1; t <= 10 && gt < 0; t++) begin
            @(negedge clk);
            if (gnt != '0) gt = t;
        end
        req[0] = 1'b0;
        total++;
        if (gt < 0) begin
            bad++; $display("FAIL midrst gnt got=none want=gnt[0]");
        end else begin
            repeat (FB_START + 4) @(negedge clk);
            total++;
            // Bit 5 of frame B {01, 0x3C} is 1.
            if (MOSI !== 1'b1 || ss_n !== 1'b0) begin
                bad++; $display("FAIL midrst pre got mosi=%b ss_n=%b want 1 0", MOSI, ss_n);
            end
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            if (ss_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || MOSI !== 1'b0) begin
                bad++; $display("FAIL midrst post got ss_n=%b busy=%b done=%b mosi=%b want 1 0 0 0",
                                ss_n, busy, done, MOSI);
            end
        end
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (done) nd++; end
        total++;
        if (nd != 0) begin bad++; $display("FAIL midrst spurious done got=%0d want=0", nd); end
        req_write = 2'b11;
        sb.push_back('{0, 8'h00, 1'b0});
        sb.push_back('{1, 8'h00, 1'b0});
        run_held(2'b11, 2);
        total++;
        if (h_ng < 2 || h_gid[0] != 0 || h_gid[1] != 1) begin
            bad++; $display("FAIL midrst ptr got first=%0d second=%0d want 0 1", h_gid[0], h_gid[1]);
        end
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            e = sb_pop();
            total++;
            if (i >= h_nd || h_did[i] != e.id || h_err[i] !== e.err) begin
                bad++; $display("FAIL midrst done[%0d] got id=%0d want id=%0d", i, h_did[i], e.id);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_read_timeout();
        test_gapped_valid();
        test_round_robin();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
